fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/FIFO_pkg.sv | 12 +
 rtl/intf.sv | 15 +
 rtl/rr_pick.sv | 46 ++++
 rtl/fifo_wr_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/FIFO_pkg.sv
// Shared configuration for the FIFO write-port arbiter: data width,
// default requester count, default burst length and the requester-id type.
package FIFO_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int BURST_LEN  = 4;
  localparam int REQ_ID_W   = $clog2(NUM_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage : FIFO_pkg

// File: rtl/intf.sv
// FIFO write-side bundle. The FIFO modport is the view of the FIFO itself
// (it consumes the write strobe and data and reports full); the ARB modport
// is the arbiter's view of the same wires.
interface intf #(
  parameter int DW = FIFO_pkg::DATA_WIDTH
) ();

  logic          Wr_enable;
  logic [DW-1:0] data_in;
  logic          full;

  modport FIFO (input Wr_enable, input data_in, output full);
  modport ARB  (output Wr_enable, output data_in, input full);

endinterface : intf

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first asserted request at or above
// ptr, wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  // req rotated so that bit 0 is the requester at ptr
  logic [N-1:0]  rot_s;
  // ptr + offset before the modulo-N fold
  logic [ID_W:0] sum_s;

  // Rotate, take the lowest set bit, and map its offset back to an index
  always_comb begin
    rot_s = N'({req, req} >> ptr);
    sum_s = '0;
    id    = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot_s[k]) begin
        valid = 1'b1;
        sum_s = {1'b0, ptr} + (ID_W+1)'(k);
        if (sum_s >= (ID_W+1)'(N)) begin
          id = ID_W'(sum_s - (ID_W+1)'(N));
        end else begin
          id = sum_s[ID_W-1:0];
        end
      end else begin
        // an earlier offset already won; keep it
        valid = valid;
      end
    end
    if (valid) begin
      gnt = N'(1) << id;
    end else begin
      gnt = '0;
    end
  end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// requesters with zero-cycle latency from request to FIFO write.
// Optional burst lock is compiled in with the macro ARB_BURST_EN: the
// arbiter then keeps granting the same requester for up to BURST_LEN
// consecutive grants and exposes arb_locked.
module fifo_wr_arbiter
  import FIFO_pkg::DATA_WIDTH;
#(
  parameter  int NUM_REQ   = FIFO_pkg::NUM_REQ,
  parameter  int BURST_LEN = FIFO_pkg::BURST_LEN,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ID_W-1:0]               gnt_id,
  input  logic                          full,
  output logic                          Wr_enable,
  output logic [DATA_WIDTH-1:0]         data_in
`ifdef ARB_BURST_EN
 ,output logic                          arb_locked
`endif
);

  if (NUM_REQ < 2) begin : g_num_req_check
    $error("fifo_wr_arbiter: NUM_REQ must be at least 2");
  end
  if (BURST_LEN < 1) begin : g_burst_len_check
    $error("fifo_wr_arbiter: BURST_LEN must be at least 1");
  end

  // Index after id, wrapping from NUM_REQ-1 to 0
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] cur);
    if (cur == ID_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return cur + 1'b1;
    end
  endfunction

  // Round-robin pointer: the requester searched first on the next pick
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               pick_valid_s;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  // Lock state: locked requester and number of grants it has had so far.
  // ptr_q already points past the locked requester, so releasing the lock
  // needs no pointer update.
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt_s),
    .id    (pick_id_s),
    .valid (pick_valid_s)
  );

  // Grant selection and next-state; full or reset freezes all state
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    ptr_d  = ptr_q;
`ifdef ARB_BURST_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
`endif
    if (reset && !full) begin
`ifdef ARB_BURST_EN
      if (lock_q && req[lock_id_q]) begin
        // continue the burst; release once BURST_LEN grants are issued
        gnt    = NUM_REQ'(1) << lock_id_q;
        gnt_id = lock_id_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(BURST_LEN)) begin
          lock_d = 1'b0;
        end else begin
          lock_d = 1'b1;
        end
      end else if (pick_valid_s) begin
        // fresh round-robin grant; a dropped lock is abandoned here too
        gnt       = pick_gnt_s;
        gnt_id    = pick_id_s;
        ptr_d     = next_id(pick_id_s);
        lock_d    = (BURST_LEN > 1) ? 1'b1 : 1'b0;
        lock_id_d = pick_id_s;
        cnt_d     = CNT_W'(1);
      end else begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end
`else
      if (pick_valid_s) begin
        gnt    = pick_gnt_s;
        gnt_id = pick_id_s;
        ptr_d  = next_id(pick_id_s);
      end else begin
        ptr_d = ptr_q;
      end
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  // FIFO write strobe and data mux driven straight from the grant
  always_comb begin
    Wr_enable = |gnt;
    if (Wr_enable) begin
      data_in = req_data[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      data_in = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
`ifdef ARB_BURST_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef ARB_BURST_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

`ifdef ARB_BURST_EN
  assign arb_locked = lock_q & reset;
`endif

endmodule : fifo_wr_arbiter
